tx_gearbox: RTL and testbench

//  Synchronous 66b->32b TX gearbox. Accepts 66-bit 64b/66b blocks from the TX PCS (encoder/scrambler) and

---
 rtl/tx_gearbox.sv | 74 +++++++
 tb/tb_tx_gearbox.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tx_gearbox.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tx_gearbox: 66b->32b TX gearbox, ready/valid in, LSB-first words out |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tx_gearbox #(
  parameter int IN_WIDTH  = 66,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_W     = $clog2(IN_WIDTH + OUT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 clk_reset,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic                 underrun
);

  localparam int               BUF_W   = IN_WIDTH + OUT_WIDTH - 1;
  localparam logic [CNT_W-1:0] C_OUT_W = CNT_W'(OUT_WIDTH);
  localparam logic [CNT_W-1:0] C_IN_W  = CNT_W'(IN_WIDTH);

  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_rem;
  logic                 started_q, started_d;
  logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                 valid_out_q;
  logic                 underrun_q;
  logic                 pop;
  logic                 push;
  logic [BUF_W-1:0]     in_ext;
  logic [BUF_W-1:0]     buf_shifted;

  // ready_in is derived from registered fill level only, so it never loops through valid_in.
  always_comb begin
    pop         = (cnt_q >= C_OUT_W);
    cnt_rem     = pop ? (cnt_q - C_OUT_W) : cnt_q;
    ready_in    = (cnt_rem < C_OUT_W) && !clk_reset;
    push        = valid_in && ready_in;
    in_ext      = {{(BUF_W-IN_WIDTH){1'b0}}, data_in};
    buf_shifted = pop ? (buf_q >> OUT_WIDTH) : buf_q;
    buf_d       = buf_shifted | (push ? (in_ext << cnt_rem) : '0);
    cnt_d       = cnt_rem + (push ? C_IN_W : '0);
    data_out_d  = pop ? buf_q[OUT_WIDTH-1:0] : data_out_q;
    started_d   = started_q | pop;
  end

  always_ff @(posedge clk) begin
    if (clk_reset) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      started_q   <= 1'b0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      started_q   <= started_d;
      data_out_q  <= data_out_d;
      valid_out_q <= pop;
      underrun_q  <= started_q && !pop;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_gearbox.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tx_gearbox: vector table + bit-queue reference model for gearbox |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_tx_gearbox;

  localparam int IW = 66;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          clk_reset = 1'b1;
  logic [IW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          ready_in;
  logic [OW-1:0] data_out;
  logic          valid_out;
  logic          underrun;

  tx_gearbox dut (
    .clk       (clk),
    .clk_reset (clk_reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending transmit bits as a plain FIFO of bits.
  bit            mq[$];
  logic [OW-1:0] m_dout = '0;
  logic          m_vout = 1'b0;
  logic          m_under = 1'b0;
  logic          m_started = 1'b0;
  int            accepted = 0;

  typedef struct {
    logic          rst;
    logic          vld;
    logic [IW-1:0] d;
    logic          e_rdy;
    logic          e_vo;
    logic [OW-1:0] e_do;
    logic          e_un;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic vld, input logic [IW-1:0] d,
                      output logic rdy_s, output logic vo_s, output logic [OW-1:0] do_s,
                      output logic un_s);
    int   rem;
    logic exp_rdy;
    bit   popped;
    clk_reset = rst;
    valid_in  = vld;
    data_in   = d;
    #1;
    rem     = (mq.size() >= OW) ? mq.size() - OW : mq.size();
    exp_rdy = !rst && (rem < OW);
    rdy_s   = ready_in;
    chk("ready_in", IW'(ready_in), IW'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_started = 1'b0;
      m_vout    = 1'b0;
      m_under   = 1'b0;
      m_dout    = '0;
    end else begin
      popped = (mq.size() >= OW);
      if (popped)
        for (int i = 0; i < OW; i++) m_dout[i] = mq.pop_front();
      if (vld && exp_rdy) begin
        for (int i = 0; i < IW; i++) mq.push_back(d[i]);
        accepted++;
      end
      m_under   = m_started && !popped;
      m_vout    = popped;
      m_started = m_started | popped;
    end
    #1;
    vo_s = valid_out;
    do_s = data_out;
    un_s = underrun;
    chk("valid_out", IW'(valid_out), IW'(m_vout));
    chk("data_out",  IW'(data_out),  IW'(m_dout));
    chk("underrun",  IW'(underrun),  IW'(m_under));
  endtask

  initial begin
    logic [IW-1:0] blk_a, blk_b, blk_c, blk_d, d;
    logic [95:0]   r;
    logic          rdy, vo, un;
    logic [OW-1:0] dw;
    int            rdy_cnt, gaps, cyc;
    bit            seen_vo;
    longint        blk_idx;

    blk_a = {64'h0123456789ABCDEF, 2'b01};
    blk_b = {64'hFEDCBA9876543210, 2'b10};
    blk_c = 66'h2_DEAD_BEEF_CAFE_F00D;
    blk_d = 66'h1_5A5A_0F0F_C3C3_9696;

    // Bit-order pair, then drain; then a lone block followed by idle.
    tbl[0]  = '{1'b1, 1'b0, '0,    1'b0, 1'b0, 32'h0,          1'b0};
    tbl[1]  = '{1'b0, 1'b1, blk_a, 1'b1, 1'b0, 32'h0,          1'b0};
    tbl[2]  = '{1'b0, 1'b1, blk_b, 1'b0, 1'b1, 32'h26AF37BD,   1'b0};
    tbl[3]  = '{1'b0, 1'b1, blk_b, 1'b1, 1'b1, blk_a[63:32],   1'b0};
    tbl[4]  = '{1'b0, 1'b0, '0,    1'b0, 1'b1, {blk_b[29:0], blk_a[65:64]}, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, '0,    1'b1, 1'b1, blk_b[61:30],   1'b0};
    tbl[6]  = '{1'b0, 1'b0, '0,    1'b1, 1'b0, blk_b[61:30],   1'b1};
    tbl[7]  = '{1'b1, 1'b0, '0,    1'b0, 1'b0, 32'h0,          1'b0};
    tbl[8]  = '{1'b0, 1'b1, blk_c, 1'b1, 1'b0, 32'h0,          1'b0};
    tbl[9]  = '{1'b0, 1'b0, '0,    1'b0, 1'b1, blk_c[31:0],    1'b0};
    tbl[10] = '{1'b0, 1'b0, '0,    1'b1, 1'b1, blk_c[63:32],   1'b0};
    tbl[11] = '{1'b0, 1'b0, '0,    1'b1, 1'b0, blk_c[63:32],   1'b1};
    tbl[12] = '{1'b0, 1'b0, '0,    1'b1, 1'b0, blk_c[63:32],   1'b1};
    tbl[13] = '{1'b0, 1'b0, '0,    1'b1, 1'b0, blk_c[63:32],   1'b1};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].d, rdy, vo, dw, un);
      chk($sformatf("vec%0d_ready", i), IW'(rdy), IW'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_vout", i),  IW'(vo),  IW'(tbl[i].e_vo));
      chk($sformatf("vec%0d_dout", i),  IW'(dw),  IW'(tbl[i].e_do));
      chk($sformatf("vec%0d_under", i), IW'(un),  IW'(tbl[i].e_un));
    end

    // Steady state: 330 cycles with valid_in held high.
    step(1'b1, 1'b0, '0, rdy, vo, dw, un);
    accepted = 0;
    rdy_cnt  = 0;
    gaps     = 0;
    seen_vo  = 0;
    blk_idx  = 0;
    for (int k = 0; k < 330; k++) begin
      d = {blk_idx[63:0], 2'b10};
      step(1'b0, 1'b1, d, rdy, vo, dw, un);
      if (rdy) begin
        rdy_cnt++;
        blk_idx++;
      end
      if (seen_vo && !vo) gaps++;
      if (vo) seen_vo = 1;
    end
    chk("steady_ready_count", IW'(rdy_cnt), IW'(160));
    chk("steady_accepts", IW'(accepted), IW'(160));
    chk("steady_vout_gaps", IW'(gaps), IW'(0));

    // Reset for one cycle mid-stream, then a fresh block.
    step(1'b1, 1'b1, blk_a, rdy, vo, dw, un);
    chk("midrst_vout", IW'(vo), IW'(0));
    chk("midrst_under", IW'(un), IW'(0));
    step(1'b0, 1'b1, blk_d, rdy, vo, dw, un);
    chk("midrst_ready", IW'(rdy), IW'(1));
    step(1'b0, 1'b0, '0, rdy, vo, dw, un);
    chk("midrst_first_word", IW'(dw), IW'(blk_d[31:0]));
    chk("midrst_first_vout", IW'(vo), IW'(1));

    // Random stream with idles, a forced 5-cycle gap and data changing under backpressure.
    step(1'b1, 1'b0, '0, rdy, vo, dw, un);
    accepted = 0;
    cyc      = 0;
    while (accepted < 10000 && cyc < 40000) begin
      r = {$urandom(), $urandom(), $urandom()};
      d = r[IW-1:0];
      if (cyc >= 500 && cyc < 505)
        step(1'b0, 1'b0, d, rdy, vo, dw, un);
      else
        step(1'b0, ($urandom_range(0, 7) != 0), d, rdy, vo, dw, un);
      cyc++;
    end
    chk("random_accepts", IW'(accepted >= 10000), IW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
